// File: rtl/pc_unit_if.sv
// Fetch handshake and execute-stage redirect bus for pc_unit.
// The execute/fetch side drives the master modport; pc_unit uses the slave modport.
interface pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_ready;
  logic              fetch_valid;
  logic [ADDR_W-1:0] current_pc;
  logic              redirect_valid;
  logic [1:0]        pc_sel;
  logic              alu_branch_result;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] abs_addr;
  logic [ADDR_W-1:0] reg_addr;
  logic              link;
  logic [ADDR_W-1:0] link_pc;
  logic              addr_err;
  logic              ras_empty;

  modport master (
    output fetch_ready, redirect_valid, pc_sel, alu_branch_result,
           branch_addr, abs_addr, reg_addr, link, link_pc,
    input  fetch_valid, current_pc, addr_err, ras_empty
  );

  modport slave (
    input  fetch_ready, redirect_valid, pc_sel, alu_branch_result,
           branch_addr, abs_addr, reg_addr, link, link_pc,
    output fetch_valid, current_pc, addr_err, ras_empty
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: registered PC, fetch handshake, execute redirects.
// Define PC_RAS_EN to add a circular return-address stack predicting pc_sel==3 targets.
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter int                PC_STEP   = 4,
  parameter int                RAS_DEPTH = 4
) (
  input  logic      clk,
  input  logic      clr,
  pc_unit_if.slave  bus
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [ADDR_W-1:0] pc_r;
  logic              valid_r;
  logic              err_r;

  logic              taken_s;
  logic [ADDR_W-1:0] target_s;
  logic              ras_avail_s;
  logic [ADDR_W-1:0] ras_top_s;

  assign bus.current_pc  = pc_r;
  assign bus.fetch_valid = valid_r;
  assign bus.addr_err    = err_r;

`ifdef PC_RAS_EN
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
  logic [IDX_W-1:0]  ras_ptr_r;
  logic [CNT_W-1:0]  ras_cnt_r;
  logic              ras_pop_s;
  logic              ras_push_s;
  logic [ADDR_W-1:0] ras_push_val_s;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(RAS_DEPTH - 1)) return {IDX_W{1'b0}};
    else return idx + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] idx);
    if (idx == {IDX_W{1'b0}}) return IDX_W'(RAS_DEPTH - 1);
    else return idx - IDX_W'(1);
  endfunction

  assign ras_avail_s    = (ras_cnt_r != {CNT_W{1'b0}});
  assign ras_top_s      = ras_mem_r[ras_ptr_r];
  assign ras_pop_s      = taken_s & (bus.pc_sel == 2'd3) & ras_avail_s;
  assign ras_push_s     = taken_s & bus.link;
  assign ras_push_val_s = bus.link_pc + STEP;
  assign bus.ras_empty  = ~ras_avail_s;

  // Stack update: pop+push overwrites the top in place; a push when full reuses the oldest slot.
  always_ff @(posedge clk) begin
    if (clr) begin
      ras_ptr_r <= {IDX_W{1'b0}};
      ras_cnt_r <= {CNT_W{1'b0}};
    end else if (ras_pop_s && ras_push_s) begin
      ras_mem_r[ras_ptr_r] <= ras_push_val_s;
    end else if (ras_pop_s) begin
      ras_ptr_r <= idx_dec(ras_ptr_r);
      ras_cnt_r <= ras_cnt_r - CNT_W'(1);
    end else if (ras_push_s) begin
      ras_ptr_r                     <= idx_inc(ras_ptr_r);
      ras_mem_r[idx_inc(ras_ptr_r)] <= ras_push_val_s;
      if (ras_cnt_r != CNT_W'(RAS_DEPTH)) begin
        ras_cnt_r <= ras_cnt_r + CNT_W'(1);
      end
    end
  end
`else
  logic unused_s;

  assign ras_avail_s   = 1'b0;
  assign ras_top_s     = {ADDR_W{1'b0}};
  assign bus.ras_empty = 1'b1;
  assign unused_s      = ^{bus.link, bus.link_pc};
`endif

  // Redirect decode: a redirect is taken only for a real jump or a satisfied branch.
  always_comb begin
    taken_s  = 1'b0;
    target_s = {ADDR_W{1'b0}};
    if (bus.redirect_valid) begin
      case (bus.pc_sel)
        2'd1: begin
          taken_s  = bus.alu_branch_result;
          target_s = bus.branch_addr;
        end
        2'd2: begin
          taken_s  = 1'b1;
          target_s = bus.abs_addr;
        end
        2'd3: begin
          taken_s = 1'b1;
          if (ras_avail_s) begin
            target_s = ras_top_s;
          end else begin
            target_s = bus.reg_addr;
          end
        end
        default: begin
          taken_s  = 1'b0;
          target_s = {ADDR_W{1'b0}};
        end
      endcase
    end else begin
      taken_s  = 1'b0;
      target_s = {ADDR_W{1'b0}};
    end
  end

  // PC register: redirect flushes regardless of fetch_ready; otherwise advance on accept.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_r    <= RESET_PC;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= 1'b1;
      if (taken_s) begin
        pc_r <= target_s & ALIGN_MASK;
        if (target_s[1:0] != 2'b00) begin
          err_r <= 1'b1;
        end
      end else if (valid_r && bus.fetch_ready) begin
        pc_r <= pc_r + STEP;
      end
    end
  end

endmodule
